// File: rtl/avm_delay_pkg.sv
// Shared definitions for the Avalon-MM delay-line initiator: FSM state
// codes, Avalon idle levels and helpers that size the circular buffer and
// clamp the requested tap delay to what the buffer can hold.
package avm_delay_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  // FSM state codes
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WRITE     = 3'd1;
  localparam logic [2:0] ST_READ      = 3'd2;
  localparam logic [2:0] ST_WAIT_DATA = 3'd3;
  localparam logic [2:0] ST_OUT       = 3'd4;

  // Avalon levels when the bus is idle / when a transfer is active
  localparam logic       AVM_STROBE_IDLE = 1'b1;
  localparam logic       AVM_STROBE_ON   = 1'b0;
  localparam logic [1:0] AVM_BE_IDLE     = 2'b11;
  localparam logic [1:0] AVM_BE_ALL      = 2'b00;

  // Number of 16-bit words in the circular buffer
  function automatic int unsigned buf_words(input int ptr_bits);
    return 32'd1 << ptr_bits;
  endfunction

  // Largest delay the buffer can represent is BUF_WORDS-1 samples
  function automatic logic [ADDR_W-1:0] clamp_delay(input logic [ADDR_W-1:0] delay,
                                                    input int ptr_bits);
    logic [ADDR_W-1:0] max_eff;
    max_eff = ADDR_W'(buf_words(ptr_bits) - 32'd1);
    return (delay > max_eff) ? max_eff : delay;
  endfunction

endpackage

// File: rtl/avm_ring_ptr.sv
// Circular-buffer bookkeeping for the delay line: write pointer, count of
// slots written since reset (saturating at BUF_WORDS-1), and the modular
// read pointer for the requested delay. prime_zero flags that the slot the
// read pointer lands on has never been written since reset.
module avm_ring_ptr
  import avm_delay_pkg::*;
#(
  parameter int PTR_BITS = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                advance,
  input  logic [ADDR_W-1:0]   delay_words,
  output logic [PTR_BITS-1:0] wr_ptr,
  output logic [PTR_BITS-1:0] rd_ptr,
  output logic                prime_zero
);

  logic [PTR_BITS-1:0] fill;
  logic [ADDR_W-1:0]   eff;

  assign eff        = clamp_delay(delay_words, PTR_BITS);
  assign rd_ptr     = wr_ptr - PTR_BITS'(eff);
  assign prime_zero = eff > ADDR_W'(fill);

  // Advance the write pointer and fill level once per completed write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (advance) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill != '1) begin
        fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/avm_delay_line_master.sv
// Avalon-MM initiator implementing an SDRAM-backed audio delay line.
// Each accepted sample is written to the circular buffer, then the sample
// written delay_words samples earlier is read back and presented downstream.
// One sample is in flight at a time. Optional statistics counters
// (stall_cycles, timeout_count, stats_clr) are built when the macro
// AVM_DELAY_STATS_EN is defined.
module avm_delay_line_master
  import avm_delay_pkg::*;
#(
  parameter int          PTR_BITS    = 16,
  parameter logic [24:0] BASE_ADDR   = 25'h0,
  parameter int          RD_DATA_DLY = 0,
  parameter int          RD_TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sample,
  input  logic [24:0] delay_words,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sample,
  output logic        timeout_err,
`ifdef AVM_DELAY_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] stall_cycles,
  output logic [15:0] timeout_count,
`endif
  output logic        chipselect,
  output logic        write_n,
  output logic        read_n,
  output logic [1:0]  byteenable_n,
  output logic [24:0] address,
  output logic [15:0] write_data,
  input  logic [15:0] read_data,
  input  logic        wait_request,
  input  logic        data_validation
);

  logic [2:0]          state;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr_next;
  logic [PTR_BITS-1:0] rd_ptr_q;
  logic                prime_next;
  logic                prime_q;
  logic                dv_seen;
  logic [15:0]         tmo_cnt;
  logic                ring_advance;
  logic                timeout_hit;
  logic [15:0]         read_value;

  assign ring_advance = (state == ST_WRITE) && !wait_request;
  assign read_value   = prime_q ? 16'h0000 : read_data;

  avm_ring_ptr #(
    .PTR_BITS(PTR_BITS)
  ) u_ring_ptr (
    .clock      (clock),
    .reset_n    (reset_n),
    .advance    (ring_advance),
    .delay_words(delay_words),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr_next),
    .prime_zero (prime_next)
  );

  // Read is abandoned once RD_TIMEOUT cycles pass in WAIT_DATA with no data
  always_comb begin
    timeout_hit = 1'b0;
    if ((state == ST_WAIT_DATA) && !dv_seen && !data_validation &&
        (tmo_cnt == 16'(RD_TIMEOUT - 1))) begin
      timeout_hit = 1'b1;
    end
  end

  // Main transaction sequencer: accept, write, read, wait for data, present
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_sample   <= 16'h0000;
      timeout_err  <= 1'b0;
      chipselect   <= 1'b0;
      write_n      <= AVM_STROBE_IDLE;
      read_n       <= AVM_STROBE_IDLE;
      byteenable_n <= AVM_BE_IDLE;
      address      <= '0;
      write_data   <= 16'h0000;
      rd_ptr_q     <= '0;
      prime_q      <= 1'b0;
      dv_seen      <= 1'b0;
      tmo_cnt      <= 16'h0000;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_ready && in_valid) begin
            in_ready     <= 1'b0;
            chipselect   <= 1'b1;
            write_n      <= AVM_STROBE_ON;
            byteenable_n <= AVM_BE_ALL;
            address      <= BASE_ADDR + ADDR_W'(wr_ptr);
            write_data   <= in_sample;
            rd_ptr_q     <= rd_ptr_next;
            prime_q      <= prime_next;
            state        <= ST_WRITE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (!wait_request) begin
            write_n <= AVM_STROBE_IDLE;
            read_n  <= AVM_STROBE_ON;
            address <= BASE_ADDR + ADDR_W'(rd_ptr_q);
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          if (!wait_request) begin
            read_n       <= AVM_STROBE_IDLE;
            chipselect   <= 1'b0;
            byteenable_n <= AVM_BE_IDLE;
            tmo_cnt      <= 16'h0000;
            dv_seen      <= 1'b0;
            state        <= ST_WAIT_DATA;
            if (data_validation) begin
              if (RD_DATA_DLY == 0) begin
                out_sample <= read_value;
                state      <= ST_OUT;
              end else begin
                dv_seen <= 1'b1;
              end
            end
          end
        end
        ST_WAIT_DATA: begin
          if (dv_seen || (data_validation && (RD_DATA_DLY == 0))) begin
            out_sample <= read_value;
            dv_seen    <= 1'b0;
            state      <= ST_OUT;
          end else if (data_validation) begin
            dv_seen <= 1'b1;
          end else if (timeout_hit) begin
            out_sample  <= 16'h0000;
            timeout_err <= 1'b1;
            state       <= ST_OUT;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ST_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef AVM_DELAY_STATS_EN
  // Saturating bus-stall and read-timeout statistics
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles  <= 32'h0;
      timeout_count <= 16'h0;
    end else if (stats_clr) begin
      stall_cycles  <= 32'h0;
      timeout_count <= 16'h0;
    end else begin
      if (chipselect && wait_request && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (timeout_hit && (timeout_count != '1)) begin
        timeout_count <= timeout_count + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_avm_delay_line_master.sv
// Self-checking bench for avm_delay_line_master. An SDRAM slave model with
// programmable stalls answers the Avalon port; a queue of every accepted
// sample since reset predicts each delayed output and bus address.
// Build with AVM_DELAY_STATS_EN defined to also check the statistics ports.
module tb_avm_delay_line_master;

  localparam int          PTR_BITS   = 4;
  localparam int          BUF_WORDS  = 16;
  localparam logic [24:0] BASE       = 25'h0100;
  localparam int          RD_TIMEOUT = 10;
  localparam int          BASE_LAT   = 5;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sample;
  logic [24:0] delay_words;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sample;
  logic        timeout_err;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [1:0]  byteenable_n;
  logic [24:0] address;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        wait_request;
  logic        data_validation;
`ifdef AVM_DELAY_STATS_EN
  logic        stats_clr;
  logic [31:0] stall_cycles;
  logic [15:0] timeout_count;
`endif

  int checks = 0;
  int errors = 0;

  // slave model state
  logic [15:0] mem [0:BUF_WORDS-1];
  int          wr_stall_cfg = 0;
  int          rd_stall_cfg = 0;
  bit          dv_enable    = 1'b1;
  int          n_writes     = 0;
  int          n_reads      = 0;
  int          stab_err     = 0;
  int          range_err    = 0;
  int          tmo_pulses   = 0;
  logic [24:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  logic [24:0] last_rd_addr = '0;

  // reference model: every sample accepted since reset, in order
  logic [15:0] hist [$];

  avm_delay_line_master #(
    .PTR_BITS   (PTR_BITS),
    .BASE_ADDR  (BASE),
    .RD_DATA_DLY(0),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sample      (in_sample),
    .delay_words    (delay_words),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sample     (out_sample),
    .timeout_err    (timeout_err),
`ifdef AVM_DELAY_STATS_EN
    .stats_clr      (stats_clr),
    .stall_cycles   (stall_cycles),
    .timeout_count  (timeout_count),
`endif
    .chipselect     (chipselect),
    .write_n        (write_n),
    .read_n         (read_n),
    .byteenable_n   (byteenable_n),
    .address        (address),
    .write_data     (write_data),
    .read_data      (read_data),
    .wait_request   (wait_request),
    .data_validation(data_validation)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SDRAM slave: decides wait_request for the coming edge, stores writes,
  // returns read data two edges after a read is accepted
  initial begin : slave
    bit          in_w;
    bit          in_r;
    int          stall_left;
    int          dv_cd;
    logic [24:0] snap_addr;
    logic [15:0] snap_data;
    logic [15:0] rd_val;
    in_w = 1'b0; in_r = 1'b0; stall_left = 0; dv_cd = 0;
    snap_addr = '0; snap_data = '0; rd_val = '0;
    wait_request = 1'b0; data_validation = 1'b0; read_data = 16'h0;
    for (int i = 0; i < BUF_WORDS; i++) mem[i] = 16'($urandom);
    forever begin
      @(negedge clock);
      if (timeout_err === 1'b1) tmo_pulses++;
      data_validation = 1'b0;
      if (dv_cd > 0) begin
        dv_cd--;
        if (dv_cd == 0 && dv_enable) begin
          data_validation = 1'b1;
          read_data = rd_val;
        end
      end
      if (chipselect === 1'b1 && write_n === 1'b0) begin
        in_r = 1'b0;
        if (!in_w) begin
          in_w = 1'b1; stall_left = wr_stall_cfg;
          snap_addr = address; snap_data = write_data;
        end
        if (address !== snap_addr || write_data !== snap_data ||
            read_n !== 1'b1 || byteenable_n !== 2'b00) stab_err++;
        if (stall_left > 0) begin
          wait_request = 1'b1; stall_left--;
        end else begin
          wait_request = 1'b0; in_w = 1'b0;
          if (address >= BASE && address < BASE + 25'(BUF_WORDS))
            mem[int'(address - BASE)] = write_data;
          else range_err++;
          n_writes++; last_wr_addr = address; last_wr_data = write_data;
        end
      end else if (chipselect === 1'b1 && read_n === 1'b0) begin
        in_w = 1'b0;
        if (!in_r) begin
          in_r = 1'b1; stall_left = rd_stall_cfg; snap_addr = address;
        end
        if (address !== snap_addr || write_n !== 1'b1 || byteenable_n !== 2'b00) stab_err++;
        if (stall_left > 0) begin
          wait_request = 1'b1; stall_left--;
        end else begin
          wait_request = 1'b0; in_r = 1'b0;
          if (address >= BASE && address < BASE + 25'(BUF_WORDS))
            rd_val = mem[int'(address - BASE)];
          else begin
            range_err++; rd_val = 16'hDEAD;
          end
          n_reads++; last_rd_addr = address; dv_cd = 2;
        end
      end else begin
        wait_request = 1'b0; in_w = 1'b0; in_r = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sample = 16'h0; delay_words = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_sample", out_sample, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_chipselect", chipselect, 0);
    checkOutput("rst_write_n", write_n, 1);
    checkOutput("rst_read_n", read_n, 1);
    checkOutput("rst_byteenable_n", byteenable_n, 2'b11);
    checkOutput("rst_address", address, 0);
    checkOutput("rst_write_data", write_data, 0);
    hist.delete();
    reset_n = 1'b1;
  endtask

  // One full sample transaction; exp_lat < 0 skips the latency check
  task automatic applyStimulus(input logic [15:0] sample, input logic [24:0] delay,
                               input int hold_cycles, input int exp_lat,
                               input bit expect_timeout);
    int          n, eff, lat, waited, wr0, rd0;
    logic [15:0] expv;
    logic [24:0] exp_wr, exp_rd;
    waited = 0;
    @(negedge clock);
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clock); waited++;
    end
    checkOutput("in_ready_wait", in_ready, 1);
    if (in_ready !== 1'b1) return;
    n   = hist.size();
    eff = (delay > 25'(BUF_WORDS - 1)) ? BUF_WORDS - 1 : int'(delay);
    hist.push_back(sample);
    if (expect_timeout || eff > ((n < BUF_WORDS - 1) ? n : BUF_WORDS - 1)) expv = 16'h0;
    else expv = hist[n - eff];
    exp_wr = BASE + 25'(n % BUF_WORDS);
    exp_rd = BASE + 25'(((n - eff) % BUF_WORDS + BUF_WORDS) % BUF_WORDS);
    wr0 = n_writes; rd0 = n_reads;
    in_valid = 1'b1; in_sample = sample; delay_words = delay;
    @(posedge clock);
    #1;
    in_valid = 1'b0; delay_words = 25'($urandom);
    lat = 0;
    do begin
      @(posedge clock); lat++;
      @(negedge clock);
    end while (out_valid !== 1'b1 && lat < 200);
    checkOutput("out_valid_wait", out_valid, 1);
    if (out_valid !== 1'b1) return;
    if (exp_lat >= 0) checkOutput("latency", lat, exp_lat);
    checkOutput("out_sample", out_sample, expv);
    checkOutput("wr_addr", last_wr_addr, exp_wr);
    checkOutput("wr_data", last_wr_data, sample);
    checkOutput("rd_addr", last_rd_addr, exp_rd);
    checkOutput("write_count", n_writes - wr0, 1);
    checkOutput("read_count", n_reads - rd0, 1);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clock);
      checkOutput("hold_out_sample", out_sample, expv);
      checkOutput("hold_out_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin : main
    int t0, wait_cyc;
`ifdef AVM_DELAY_STATS_EN
    int s0, c0;
    stats_clr = 1'b0;
`endif
    doReset();

    $display("[TB] ramp 1..8 with delay 3");
    for (int i = 1; i <= 8; i++) applyStimulus(16'(i), 25'd3, 0, BASE_LAT, 1'b0);

    $display("[TB] random data with delay 2 across several wraps");
    for (int i = 0; i < 40; i++) applyStimulus(16'($urandom), 25'd2, 0, BASE_LAT, 1'b0);

    $display("[TB] write stalled 4 cycles, read stalled 3 cycles");
`ifdef AVM_DELAY_STATS_EN
    s0 = int'(stall_cycles);
`endif
    wr_stall_cfg = 4; rd_stall_cfg = 3;
    applyStimulus(16'($urandom), 25'd5, 0, BASE_LAT + 7, 1'b0);
    wr_stall_cfg = 0; rd_stall_cfg = 0;
    checkOutput("stall_stability", stab_err, 0);
`ifdef AVM_DELAY_STATS_EN
    checkOutput("stall_cycles", stall_cycles - 32'(s0), 7);
`endif

    $display("[TB] read timeout");
    t0 = tmo_pulses;
`ifdef AVM_DELAY_STATS_EN
    c0 = int'(timeout_count);
`endif
    dv_enable = 1'b0;
    applyStimulus(16'($urandom), 25'd1, 0, -1, 1'b1);
    dv_enable = 1'b1;
    checkOutput("timeout_pulses", tmo_pulses - t0, 1);
`ifdef AVM_DELAY_STATS_EN
    checkOutput("timeout_count", timeout_count - 16'(c0), 1);
`endif
    applyStimulus(16'($urandom), 25'd1, 0, BASE_LAT, 1'b0);

    $display("[TB] maximum delay clamped to buffer depth");
    doReset();
    for (int i = 0; i < 18; i++) applyStimulus(16'(i + 1), 25'h1FFFFFF, 0, BASE_LAT, 1'b0);

    $display("[TB] random delays");
    for (int i = 0; i < 20; i++)
      applyStimulus(16'($urandom), (i % 5 == 0) ? 25'($urandom) : 25'($urandom_range(0, 20)),
                    0, BASE_LAT, 1'b0);

    $display("[TB] back-pressure then reset during write");
    applyStimulus(16'($urandom), 25'd4, 6, BASE_LAT, 1'b0);
    wr_stall_cfg = 20;
    wait_cyc = 0;
    @(negedge clock);
    while (in_ready !== 1'b1 && wait_cyc < 50) begin
      @(negedge clock); wait_cyc++;
    end
    in_valid = 1'b1; in_sample = 16'hBEEF; delay_words = 25'd0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("mid_write_chipselect", chipselect, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_chipselect", chipselect, 0);
    checkOutput("async_rst_write_n", write_n, 1);
    checkOutput("async_rst_read_n", read_n, 1);
    checkOutput("async_rst_byteenable_n", byteenable_n, 2'b11);
    wr_stall_cfg = 0;
    repeat (2) @(negedge clock);
    hist.delete();
    reset_n = 1'b1;
    applyStimulus(16'h1234, 25'd0, 0, BASE_LAT, 1'b0);
    applyStimulus(16'h5678, 25'd1, 0, BASE_LAT, 1'b0);

    checkOutput("bus_stability", stab_err, 0);
    checkOutput("addr_range", range_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
